block_mem_arbiter: RTL and testbench

- Arbitrates the single block-wide instruction/data memory port between two requesters: instruction-cache refill (I side) and data-cache refill/writeback (D side).
- Sits between the caches and the backing memory.
- Sequences each transfer through a small FSM: grant, hold the memory request until acknowledged, return one done pulse to the owner.
- Only one transfer is outstanding at a time; ties are resolved round-robin.

---
 rtl/block_mem_arbiter_if.sv | 31 +++
 rtl/block_mem_arbiter.sv | 98 +++++++++
 tb/tb_block_mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/block_mem_arbiter_if.sv
// Cache-side and memory-side signals of the block memory arbiter.
// master is the arbiter's view; slave is the caches/memory view.
interface block_mem_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256
);
  logic               i_req;
  logic [ADDR_W-1:0]  i_addr;
  logic               i_done;
  logic               d_req;
  logic               d_we;
  logic [ADDR_W-1:0]  d_addr;
  logic [BLOCK_W-1:0] d_wdata;
  logic               d_done;
  logic [BLOCK_W-1:0] rd_data;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic               mem_ack;
  logic [BLOCK_W-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_done, d_done, rd_data, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_done, d_done, rd_data, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/block_mem_arbiter.sv
// Round-robin arbiter of the I/D cache refill port onto one block memory port.
// Optional grant/stall counters are enabled with BLOCK_MEM_ARB_PERF_EN.
module block_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int BLOCK_W  = 256,
  parameter int OFFSET_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  block_mem_arbiter_if.master bus
`ifdef BLOCK_MEM_ARB_PERF_EN
  ,
  output logic [31:0] i_grant_cnt,
  output logic [31:0] d_grant_cnt,
  output logic [31:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [ADDR_W-1:0] AMASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  state_t            state;
  logic              owner_d;  // 1: D side owns the current transfer
  logic              last_d;   // owner of the last completed transfer
  logic              grant_d;
  logic [ADDR_W-1:0] gaddr;

  // D wins only when alone or when I was served last.
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || !last_d);
    gaddr   = grant_d ? bus.d_addr : bus.i_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      last_d        <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rd_data   <= '0;
      bus.i_done    <= 1'b0;
      bus.d_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_req || bus.d_req) begin
          owner_d       <= grant_d;
          bus.mem_req   <= 1'b1;
          bus.mem_we    <= grant_d & bus.d_we;
          bus.mem_addr  <= gaddr & AMASK;
          bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
          state         <= BUSY;
        end
        BUSY: if (bus.mem_ack) begin
          if (!bus.mem_we) bus.rd_data <= bus.mem_rdata;
          bus.mem_req <= 1'b0;
          bus.mem_we  <= 1'b0;
          last_d      <= owner_d;
          bus.i_done  <= !owner_d;
          bus.d_done  <= owner_d;
          state       <= DONE;
        end
        DONE: begin
          bus.i_done <= 1'b0;
          bus.d_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BLOCK_MEM_ARB_PERF_EN
  logic i_wait, d_wait;

  // A side being granted this cycle counts as owned, not waiting.
  always_comb begin
    i_wait = bus.i_req && ((state == IDLE) ? grant_d  : owner_d);
    d_wait = bus.d_req && ((state == IDLE) ? !grant_d : !owner_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (state == IDLE && (bus.i_req || bus.d_req)) begin
        if (grant_d) d_grant_cnt <= d_grant_cnt + 32'd1;
        else         i_grant_cnt <= i_grant_cnt + 32'd1;
      end
      stall_cnt <= stall_cnt + 32'(i_wait) + 32'(d_wait);
    end
  end
`endif
endmodule

// File: tb/tb_block_mem_arbiter.sv
// Randomized bench for block_mem_arbiter against a transfer-level reference model.
// Define BLOCK_MEM_ARB_PERF_EN to also check the performance counters.
module tb_block_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_mem_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus();

`ifdef BLOCK_MEM_ARB_PERF_EN
  logic [31:0] i_gc, d_gc, st_c;
  block_mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .OFFSET_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master),
    .i_grant_cnt(i_gc), .d_grant_cnt(d_gc), .stall_cnt(st_c));
`else
  block_mem_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .OFFSET_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));
`endif

  int n_run = 0, n_fail = 0;

  // reference model state
  bit                 m_last_d;
  logic [BLOCK_W-1:0] m_rd;
  int                 m_gi, m_gd, m_stall;

  task automatic chk(input string tag, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] rnd_blk();
    logic [BLOCK_W-1:0] r;
    for (int k = 0; k < BLOCK_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_last_d = 1'b1;
    m_rd     = '0;
    m_gi = 0; m_gd = 0; m_stall = 0;
  endtask

  // Serve one transfer; called at a negedge where the owner's request is already pending.
  task automatic serve(input bit is_d, input logic [31:0] addr, input bit we,
                       input logic [BLOCK_W-1:0] wd, input int dly,
                       input logic [BLOCK_W-1:0] rdat, input bit poke);
    int w = 0;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    do begin step(); w++; end while (!bus.mem_req && w < 20);
    chk("grant_latency", w, 1);
    chk("mem_addr", bus.mem_addr, exp_addr);
    chk("mem_we", bus.mem_we, is_d & we);
    chk("mem_wdata", bus.mem_wdata, is_d ? wd : '0);
    if (poke) begin
      if (is_d) begin bus.d_addr = $urandom; bus.d_wdata = rnd_blk(); bus.d_we = ~bus.d_we; end
      else bus.i_addr = 32'hFFFF_FFE0;
    end
    for (int k = 0; k < dly; k++) begin
      step();
      chk("busy_req_hold", bus.mem_req, 1);
      chk("busy_addr_hold", bus.mem_addr, exp_addr);
      chk("busy_done_low", {bus.i_done, bus.d_done}, 2'b00);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = rdat;
    step();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = rnd_blk();
    if (!(is_d && we)) m_rd = rdat;
    m_last_d = is_d;
    chk("done_pulse", {bus.i_done, bus.d_done}, is_d ? 2'b01 : 2'b10);
    chk("rd_data", bus.rd_data, m_rd);
    chk("req_dropped", bus.mem_req, 0);
    if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    step();
    chk("done_single", {bus.i_done, bus.d_done}, 2'b00);
  endtask

  task automatic run_round(input bit ri, input bit rq, input logic [31:0] ia, input logic [31:0] da,
                           input bit dwe, input logic [BLOCK_W-1:0] dwd,
                           input int dly0, input int dly1,
                           input logic [BLOCK_W-1:0] rd0, input logic [BLOCK_W-1:0] rd1,
                           input bit poke);
    bit first_d;
    bus.i_req = ri; bus.i_addr = ia;
    bus.d_req = rq; bus.d_addr = da; bus.d_we = dwe; bus.d_wdata = dwd;
    first_d = (ri && rq) ? !m_last_d : rq;
    if (ri && rq) m_stall += dly0 + 3;
    if (ri) m_gi++;
    if (rq) m_gd++;
    if (first_d) serve(1'b1, da, dwe, dwd, dly0, rd0, poke);
    else         serve(1'b0, ia, 1'b0, dwd, dly0, rd0, poke);
    if (ri && rq) begin
      if (first_d) serve(1'b0, ia, 1'b0, dwd, dly1, rd1, 1'b0);
      else         serve(1'b1, da, dwe, dwd, dly1, rd1, 1'b0);
    end
  endtask

  initial begin
    logic [BLOCK_W-1:0] pat_a5, pat_p;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    model_reset();
    pat_a5 = {(BLOCK_W/8){8'hA5}};
    pat_p  = rnd_blk();

    step(); step();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_done", {bus.i_done, bus.d_done}, 2'b00);
    rst_n = 1'b1;

    // I read, then D writeback (rd_data must survive the write)
    run_round(1, 0, 32'h0000_0047, 32'h0, 0, '0, 2, 0, pat_a5, '0, 0);
    run_round(0, 1, 32'h0, 32'h0000_1234, 1, pat_p, 1, 0, rnd_blk(), '0, 0);
    chk("rd_kept_after_wb", bus.rd_data, pat_a5);

    // fairness: both requesting twice -> I, D, I, D
    run_round(1, 1, 32'h0000_0100, 32'h0000_0200, 0, rnd_blk(), 1, 2, rnd_blk(), rnd_blk(), 0);
    run_round(1, 1, 32'h0000_0300, 32'h0000_0400, 1, rnd_blk(), 0, 1, rnd_blk(), rnd_blk(), 0);

    // requester input change while BUSY
    run_round(1, 0, 32'h0000_5560, 32'h0, 0, '0, 3, 0, rnd_blk(), '0, 1);

    // stray ack in IDLE
    bus.mem_ack = 1'b1; bus.mem_rdata = rnd_blk();
    step();
    bus.mem_ack = 1'b0;
    step();
    chk("stray_ack_req", bus.mem_req, 0);
    chk("stray_ack_done", {bus.i_done, bus.d_done}, 2'b00);
    chk("stray_ack_rd", bus.rd_data, m_rd);

    // reset while BUSY, no ack
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0880;
    step();
    chk("pre_rst_busy", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_req", bus.mem_req, 0);
    chk("rst_busy_rd", bus.rd_data, 0);
    bus.i_req = 1'b0;
    model_reset();
    step(); step();
    chk("rst_busy_no_done", {bus.i_done, bus.d_done}, 2'b00);
    rst_n = 1'b1;
    run_round(1, 0, 32'h0000_0999, 32'h0, 0, '0, 1, 0, rnd_blk(), '0, 0);

    // random rounds
    for (int r = 0; r < 30; r++) begin
      bit ri, rq;
      ri = $urandom_range(0, 1);
      rq = $urandom_range(0, 1);
      if (!ri && !rq) ri = 1'b1;
      run_round(ri, rq, $urandom, $urandom, 1'($urandom_range(0, 1)), rnd_blk(),
                $urandom_range(0, 4), $urandom_range(0, 4), rnd_blk(), rnd_blk(),
                1'($urandom_range(0, 1)));
    end

`ifdef BLOCK_MEM_ARB_PERF_EN
    chk("i_grant_cnt", i_gc, m_gi);
    chk("d_grant_cnt", d_gc, m_gd);
    chk("stall_cnt", st_c, m_stall);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
